// File: rtl/prescaled_counter_bank_pkg.sv
// ---------------------------------------------------------------------------
// prescaled_counter_bank_pkg
// Shared types and helpers for the prescaled counter bank.
//   ovf_mode_e  : per-channel overflow policy (wrap to 0 or saturate at max)
//   clog2_min1  : ceil(log2(n)) with a floor of 1, for index widths that must
//                 stay at least one bit wide even for a single channel
// ---------------------------------------------------------------------------
package prescaled_counter_bank_pkg;

   typedef enum logic {
      OVF_WRAP = 1'b0,
      OVF_SAT  = 1'b1
   } ovf_mode_e;

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prescaled_counter_ch.sv
// ---------------------------------------------------------------------------
// prescaled_counter_ch
// One event-counter channel: programmable prescaler, main counter, sticky
// overflow flag and a one-cycle wrap pulse.
// Ports:
//   clk      in  clock, all state updates on posedge
//   rst      in  synchronous active-high reset
//   ev       in  qualified event strobe (global enable already applied)
//   clr      in  clear count, prescaler and overflow flag
//   cfg_we   in  load new divide value / overflow mode, restart prescaler
//   cfg_div  in  terminal prescale value (ratio = cfg_div + 1)
//   cfg_sat  in  1 = saturate at max, 0 = wrap to 0
//   cnt      out main counter
//   ovf      out sticky overflow flag
//   wrap     out registered pulse for the cycle following a wrap
// ---------------------------------------------------------------------------
module prescaled_counter_ch
   import prescaled_counter_bank_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ev,
   input  logic             clr,
   input  logic             cfg_we,
   input  logic [PRE_W-1:0] cfg_div,
   input  logic             cfg_sat,
   output logic [WIDTH-1:0] cnt,
   output logic             ovf,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PRE_W-1:0] div_q, div_d;
   ovf_mode_e        sat_q, sat_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             wrap_q, wrap_d;

   always_comb begin
      pre_d  = pre_q;
      div_d  = div_q;
      sat_d  = sat_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      wrap_d = 1'b0;

      // A clear or a config write in the same cycle swallows the event.
      if (ev && !clr && !cfg_we) begin
         // >= rather than == so a prescaler left above a lowered divide
         // value still terminates instead of running all the way round.
         if (pre_q >= div_q) begin
            pre_d = '0;
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + WIDTH'(1);
            end else if (sat_q == OVF_SAT) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d  = '0;
               ovf_d  = 1'b1;
               wrap_d = 1'b1;
            end
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end

      if (clr) begin
         cnt_d = '0;
         pre_d = '0;
         ovf_d = 1'b0;
      end

      if (cfg_we) begin
         div_d = cfg_div;
         sat_d = ovf_mode_e'(cfg_sat);
         pre_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q  <= '0;
         div_q  <= '0;
         sat_q  <= OVF_WRAP;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         div_q  <= div_d;
         sat_q  <= sat_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt  = cnt_q;
   assign ovf  = ovf_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/prescaled_counter_bank.sv
// ---------------------------------------------------------------------------
// prescaled_counter_bank
// Bank of NUM_CH independent prescaled event counters.
// Ports:
//   Clk        in  clock
//   Reset      in  synchronous active-high reset
//   En         in  global count enable (gates events only)
//   Inc        in  per-channel event strobes
//   Clear      in  per-channel clear of count, prescaler and overflow flag
//   CfgWe      in  configuration write strobe
//   CfgCh      in  target channel; values >= NUM_CH are ignored
//   CfgDiv     in  terminal prescale value (ratio = CfgDiv + 1)
//   CfgSat     in  1 = saturate, 0 = wrap
//   Count      out flat counters, channel i at [i*WIDTH +: WIDTH]
//   Ovf        out sticky overflow flags
//   WrapPulse  out one-cycle wrap pulses
// ---------------------------------------------------------------------------
module prescaled_counter_bank
   import prescaled_counter_bank_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int WIDTH  = 64,
   parameter  int PRE_W  = 8,
   localparam int CH_W   = clog2_min1(NUM_CH)
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    En,
   input  logic [NUM_CH-1:0]       Inc,
   input  logic [NUM_CH-1:0]       Clear,
   input  logic                    CfgWe,
   input  logic [CH_W-1:0]         CfgCh,
   input  logic [PRE_W-1:0]        CfgDiv,
   input  logic                    CfgSat,
   output logic [NUM_CH*WIDTH-1:0] Count,
   output logic [NUM_CH-1:0]       Ovf,
   output logic [NUM_CH-1:0]       WrapPulse
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic ch_ev;
      logic ch_we;

      assign ch_ev = En & Inc[i];
      // Out-of-range channel numbers match no instance and are dropped here.
      assign ch_we = CfgWe && (CfgCh == CH_W'(i));

      prescaled_counter_ch #(
         .WIDTH (WIDTH),
         .PRE_W (PRE_W)
      ) u_ch (
         .clk     (Clk),
         .rst     (Reset),
         .ev      (ch_ev),
         .clr     (Clear[i]),
         .cfg_we  (ch_we),
         .cfg_div (CfgDiv),
         .cfg_sat (CfgSat),
         .cnt     (Count[i*WIDTH +: WIDTH]),
         .ovf     (Ovf[i]),
         .wrap    (WrapPulse[i])
      );
   end

endmodule

// File: tb/tb_prescaled_counter_bank.sv
module tb_prescaled_counter_bank;

   localparam int NUM_CH = 5;
   localparam int WIDTH  = 4;
   localparam int PRE_W  = 3;
   localparam int CH_W   = 3;
   localparam int MAXV   = (1 << WIDTH) - 1;

   logic                    Clk = 1'b0;
   logic                    Reset;
   logic                    En;
   logic [NUM_CH-1:0]       Inc;
   logic [NUM_CH-1:0]       Clear;
   logic                    CfgWe;
   logic [CH_W-1:0]         CfgCh;
   logic [PRE_W-1:0]        CfgDiv;
   logic                    CfgSat;
   logic [NUM_CH*WIDTH-1:0] Count;
   logic [NUM_CH-1:0]       Ovf;
   logic [NUM_CH-1:0]       WrapPulse;

   prescaled_counter_bank #(
      .NUM_CH (NUM_CH),
      .WIDTH  (WIDTH),
      .PRE_W  (PRE_W)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .En        (En),
      .Inc       (Inc),
      .Clear     (Clear),
      .CfgWe     (CfgWe),
      .CfgCh     (CfgCh),
      .CfgDiv    (CfgDiv),
      .CfgSat    (CfgSat),
      .Count     (Count),
      .Ovf       (Ovf),
      .WrapPulse (WrapPulse)
   );

   always #5 Clk = ~Clk;

   // Reference model: per channel, events seen since last count, ratio,
   // policy, count value as a plain integer, flag and pulse.
   int m_cnt   [NUM_CH];
   int m_pend  [NUM_CH];
   int m_ratio [NUM_CH];
   bit m_sat   [NUM_CH];
   bit m_ovf   [NUM_CH];
   bit m_wrap  [NUM_CH];

   int compared   = 0;
   int mismatched = 0;
   int wraps_seen [NUM_CH];

   task automatic chk(input string tag, input int got, input int exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int cnt_of(input int c);
      return int'(Count[c*WIDTH +: WIDTH]);
   endfunction

   task automatic model_step();
      for (int c = 0; c < NUM_CH; c++) begin
         bit hit;
         bit ev;
         m_wrap[c] = 1'b0;
         if (Reset) begin
            m_cnt[c] = 0; m_pend[c] = 0; m_ratio[c] = 1;
            m_sat[c] = 1'b0; m_ovf[c] = 1'b0;
            continue;
         end
         hit = CfgWe && (int'(CfgCh) == c);
         ev  = En && Inc[c];
         if (ev && !Clear[c] && !hit) begin
            m_pend[c]++;
            if (m_pend[c] >= m_ratio[c]) begin
               m_pend[c] = 0;
               if (m_cnt[c] < MAXV) m_cnt[c]++;
               else if (m_sat[c]) m_ovf[c] = 1'b1;
               else begin
                  m_cnt[c] = 0; m_ovf[c] = 1'b1; m_wrap[c] = 1'b1;
               end
            end
         end
         if (Clear[c]) begin
            m_cnt[c] = 0; m_pend[c] = 0; m_ovf[c] = 1'b0;
         end
         if (hit) begin
            m_ratio[c] = int'(CfgDiv) + 1;
            m_sat[c]   = CfgSat;
            m_pend[c]  = 0;
         end
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < NUM_CH; c++) begin
         chk($sformatf("cnt%0d", c),  cnt_of(c),          m_cnt[c]);
         chk($sformatf("ovf%0d", c),  int'(Ovf[c]),       int'(m_ovf[c]));
         chk($sformatf("wrap%0d", c), int'(WrapPulse[c]), int'(m_wrap[c]));
         if (WrapPulse[c]) wraps_seen[c]++;
      end
   endtask

   // Apply one cycle of inputs, clock it, update the model, check outputs.
   task automatic cyc(input bit rst, input bit en, input logic [NUM_CH-1:0] inc,
                      input logic [NUM_CH-1:0] clr, input bit we,
                      input int ch, input int div, input bit sat);
      Reset  = rst;
      En     = en;
      Inc    = inc;
      Clear  = clr;
      CfgWe  = we;
      CfgCh  = CH_W'(ch);
      CfgDiv = PRE_W'(div);
      CfgSat = sat;
      @(posedge Clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      for (int c = 0; c < NUM_CH; c++) wraps_seen[c] = 0;
      Reset = 1'b1; En = 1'b0; Inc = '0; Clear = '0;
      CfgWe = 1'b0; CfgCh = '0; CfgDiv = '0; CfgSat = 1'b0;
      #1;

      // Reset
      cyc(1, 0, '0, '0, 0, 0, 0, 0);
      cyc(1, 0, '0, '0, 0, 0, 0, 0);
      chk("reset_count", int'(Count == '0), 1);
      chk("reset_ovf",   int'(Ovf), 0);

      // Ten events on ch0 at ratio 1
      for (int k = 0; k < 10; k++) cyc(0, 1, 5'b00001, '0, 0, 0, 0, 0);
      chk("plan_ch0_10", cnt_of(0), 10);
      chk("plan_others0", cnt_of(1) + cnt_of(2) + cnt_of(3) + cnt_of(4), 0);

      // ch1 at ratio 4: 13 events -> 3, 16 events -> 4 on the 16th
      cyc(0, 1, '0, '0, 1, 1, 3, 0);
      for (int k = 0; k < 13; k++) cyc(0, 1, 5'b00010, '0, 0, 0, 0, 0);
      chk("plan_ch1_3", cnt_of(1), 3);
      cyc(0, 1, 5'b00010, '0, 0, 0, 0, 0);
      cyc(0, 1, 5'b00010, '0, 0, 0, 0, 0);
      chk("plan_ch1_still3", cnt_of(1), 3);
      cyc(0, 1, 5'b00010, '0, 0, 0, 0, 0);
      chk("plan_ch1_4", cnt_of(1), 4);

      // ch2 wraps after its 16th event
      for (int k = 0; k < 17; k++) cyc(0, 1, 5'b00100, '0, 0, 0, 0, 0);
      chk("plan_ch2_1", cnt_of(2), 1);
      chk("plan_ch2_ovf", int'(Ovf[2]), 1);
      chk("plan_ch2_one_pulse", wraps_seen[2], 1);

      // ch3 saturate mode
      cyc(0, 1, '0, '0, 1, 3, 0, 1);
      for (int k = 0; k < 20; k++) cyc(0, 1, 5'b01000, '0, 0, 0, 0, 0);
      chk("plan_ch3_sat", cnt_of(3), 15);
      chk("plan_ch3_ovf", int'(Ovf[3]), 1);
      chk("plan_ch3_nopulse", wraps_seen[3], 0);
      cyc(0, 1, '0, 5'b01000, 0, 0, 0, 0);
      chk("plan_ch3_clr", cnt_of(3) + int'(Ovf[3]), 0);
      for (int k = 0; k < 16; k++) cyc(0, 1, 5'b01000, '0, 0, 0, 0, 0);
      chk("plan_ch3_sat_kept", cnt_of(3), 15);

      // Same-cycle interactions
      cyc(0, 1, 5'b00001, 5'b00001, 0, 0, 0, 0);
      chk("clr_beats_inc", cnt_of(0), 0);
      cyc(0, 1, 5'b00010, '0, 1, 1, 0, 0);
      chk("cfg_drops_inc", cnt_of(1), 4);
      cyc(0, 1, 5'b00010, '0, 0, 0, 0, 0);
      chk("cfg_ratio1", cnt_of(1), 5);
      cyc(0, 1, '0, '0, 1, NUM_CH, 7, 1);
      cyc(0, 1, '0, '0, 1, 7, 7, 1);
      cyc(0, 1, 5'b11111, '0, 0, 0, 0, 0);
      cyc(0, 1, 5'b00100, 5'b00100, 1, 2, 1, 0);
      cyc(0, 0, 5'b11111, '0, 0, 0, 0, 0);

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         bit r_rst, r_en, r_we, r_sat;
         logic [NUM_CH-1:0] r_inc, r_clr;
         int r_ch, r_div;
         r_rst = ($urandom_range(199) == 0);
         r_en  = ($urandom_range(7) != 0);
         r_inc = NUM_CH'($urandom);
         r_clr = '0;
         for (int c = 0; c < NUM_CH; c++) r_clr[c] = ($urandom_range(39) == 0);
         r_we  = ($urandom_range(11) == 0);
         r_ch  = $urandom_range(7);
         r_div = $urandom_range(3) == 0 ? $urandom_range(7) : $urandom_range(1);
         r_sat = $urandom_range(1);
         cyc(r_rst, r_en, r_inc, r_clr, r_we, r_ch, r_div, r_sat);
      end

      // Mid-run reset with all channels active, then ratio-1 counting
      cyc(0, 1, '0, '0, 1, 0, 5, 1);
      cyc(1, 1, 5'b11111, '0, 0, 0, 0, 0);
      chk("midreset_count", int'(Count == '0), 1);
      chk("midreset_ovf", int'(Ovf), 0);
      cyc(0, 1, 5'b11111, '0, 0, 0, 0, 0);
      chk("post_reset_ch0", cnt_of(0), 1);
      chk("post_reset_ch4", cnt_of(4), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
